// File: rtl/aes_pkg.sv
// Shared AES constants, the forward S-box and the word helpers used by the AES-256 key schedule.
package aes_pkg;

  localparam int unsigned NK      = 8;
  localparam int unsigned NR      = 14;
  localparam int unsigned NUM_RK  = NR + 1;
  localparam int unsigned RkAddrW = 4;

  localparam logic [RkAddrW-1:0] RkAddrMax = RkAddrW'(NUM_RK - 1);
  localparam logic [2:0]         IterLast  = 3'd7;
  // Rcon sequence is 01,02,04,...,40 in the top byte; seven steps never need GF reduction.
  localparam logic [31:0]        RconInit  = 32'h0100_0000;

  typedef enum logic [1:0] {StIdle, StExpand, StDone} ks_state_e;
  typedef logic [NK-1:0][31:0] key_words_t;

  localparam logic [7:0] SboxTable [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_schedule_256_expand.sv
// One combinational AES-256 expansion step: eight old words plus rcon give the next eight words.
module key_schedule_256_expand
  import aes_pkg::*;
(
  input  key_words_t  w,
  input  logic [31:0] rcon,
  output key_words_t  w_next
);

  // Running XOR kept in a block-local variable so each word chains off the previous new word.
  always_comb begin
    logic [31:0] acc;
    w_next    = '0;
    acc       = w[0] ^ sub_word(rot_word(w[7])) ^ rcon;
    w_next[0] = acc;
    acc       = acc ^ w[1];
    w_next[1] = acc;
    acc       = acc ^ w[2];
    w_next[2] = acc;
    acc       = acc ^ w[3];
    w_next[3] = acc;
    acc       = w[4] ^ sub_word(acc);
    w_next[4] = acc;
    acc       = acc ^ w[5];
    w_next[5] = acc;
    acc       = acc ^ w[6];
    w_next[6] = acc;
    acc       = acc ^ w[7];
    w_next[7] = acc;
  end

endmodule

// File: rtl/key_schedule_256.sv
// Sequential AES-256 key schedule: seven one-per-clock expansion steps fill a 15-entry round-key
// buffer that is read combinationally by the round datapath.
module key_schedule_256
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [255:0]   key,
  output logic           busy,
  output logic           key_valid,
  input  logic [3:0]     rk_addr,
  output logic [127:0]   rk_data
);

  ks_state_e    state_q;
  logic [2:0]   iter_q;
  logic [31:0]  rcon_q;
  key_words_t   w_q;
  key_words_t   w_next;
  logic         key_valid_q;
  logic         accept;
  logic [127:0] rk_mem [NUM_RK];

  key_schedule_256_expand u_expand (
    .w      (w_q),
    .rcon   (rcon_q),
    .w_next (w_next)
  );

  assign accept = start && (state_q == StIdle || state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      rcon_q      <= '0;
      w_q         <= '0;
      key_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            for (int i = 0; i < NK; i++) begin
              w_q[i] <= key[255 - 32*i -: 32];
            end
            iter_q      <= 3'd1;
            rcon_q      <= RconInit;
            key_valid_q <= 1'b0;
            state_q     <= StExpand;
          end
        end
        StExpand: begin
          w_q    <= w_next;
          rcon_q <= rcon_q << 1;
          if (iter_q == IterLast) begin
            key_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            iter_q <= iter_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Buffer is deliberately not reset; a reset mid-expansion leaves a partial schedule behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        rk_mem[0] <= key[255:128];
        rk_mem[1] <= key[127:0];
      end else if (state_q == StExpand) begin
        rk_mem[{iter_q, 1'b0}] <= {w_next[0], w_next[1], w_next[2], w_next[3]};
        if (iter_q != IterLast) begin
          rk_mem[{iter_q, 1'b1}] <= {w_next[4], w_next[5], w_next[6], w_next[7]};
        end
      end
    end
  end

  assign busy      = (state_q == StExpand);
  assign key_valid = key_valid_q;
  assign rk_data   = (rk_addr <= RkAddrMax) ? rk_mem[rk_addr] : '0;

endmodule
